// File: rtl/fp_result_encoder.sv
`default_nettype none
// ============================================================================
// Module   : fp_result_encoder
// Purpose  : Packs unpacked FP result fields into single or half IEEE-754
//            words; half subnormals are denormalised one bit per cycle.
// Revision : 1.0  initial release
// ============================================================================
module fp_result_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mode_fp,
   input  logic        result_sign,
   input  logic [7:0]  result_exp,
   input  logic [22:0] result_mant,
   input  logic        overflow,
   input  logic        underflow,
   input  logic        inexact,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic [2:0]  out_flags,
   output logic [2:0]  status_flags,
   input  logic        flags_clr
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CALC  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_ROUND = 3'd3,
      ST_OUT   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        mode_q, mode_d;
   logic        sign_q, sign_d;
   logic [7:0]  exp_q, exp_d;
   logic [22:0] mant_q, mant_d;
   logic [2:0]  fin_q, fin_d;
   logic [24:0] sh_q, sh_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        sticky_q, sticky_d;
   logic [31:0] word_q, word_d;
   logic [2:0]  flags_q, flags_d;
   logic [2:0]  status_q, status_d;

   // Half normal: exponent rebias by 112 is done modulo 32, exact for 113..142
   logic [9:0]  w_nrm_frac;
   logic        w_nrm_g, w_nrm_s, w_nrm_up, w_nrm_inf;
   logic [10:0] w_nrm_frac_rnd;
   logic [4:0]  w_nrm_e5;
   logic [15:0] w_nrm_word;

   assign w_nrm_frac     = mant_q[22:13];
   assign w_nrm_g        = mant_q[12];
   assign w_nrm_s        = |mant_q[11:0];
   assign w_nrm_up       = w_nrm_g & (w_nrm_s | w_nrm_frac[0]);
   assign w_nrm_frac_rnd = {1'b0, w_nrm_frac} + {10'd0, w_nrm_up};
   assign w_nrm_e5       = exp_q[4:0] - 5'd16 + {4'd0, w_nrm_frac_rnd[10]};
   assign w_nrm_inf      = (w_nrm_e5 == 5'd31);
   assign w_nrm_word     = w_nrm_inf ? {sign_q, 5'h1F, 10'd0}
                                     : {sign_q, w_nrm_e5, w_nrm_frac_rnd[9:0]};

   logic [7:0]  w_sub_eeff, w_sub_dist;
   logic [4:0]  w_sub_cnt;
   logic        w_rnd_g, w_rnd_up, w_rnd_ix;
   logic [14:0] w_rnd_mag;
   logic        w_hs;

   assign w_sub_eeff = (exp_q == 8'd0) ? 8'd1 : exp_q;
   assign w_sub_dist = 8'd126 - w_sub_eeff;
   assign w_sub_cnt  = (w_sub_dist > 8'd26) ? 5'd26 : w_sub_dist[4:0];
   assign w_rnd_g    = sh_q[0];
   assign w_rnd_up   = w_rnd_g & (sticky_q | sh_q[1]);
   assign w_rnd_mag  = sh_q[15:1] + {14'd0, w_rnd_up};
   assign w_rnd_ix   = fin_q[0] | w_rnd_g | sticky_q;
   assign w_hs       = (state_q == ST_OUT) & out_ready;

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      mant_d   = mant_q;
      fin_d    = fin_q;
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      word_d   = word_q;
      flags_d  = flags_q;
      status_d = status_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               mode_d  = mode_fp;
               sign_d  = result_sign;
               exp_d   = result_exp;
               mant_d  = result_mant;
               fin_d   = {overflow, underflow, inexact};
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            state_d = ST_OUT;
            if (mode_q) begin
               word_d  = (fin_q[2] || exp_q == 8'hFF) ? {sign_q, 8'hFF, 23'd0}
                                                      : {sign_q, exp_q, mant_q};
               flags_d = fin_q;
            end else if (exp_q == 8'd0 && mant_q == 23'd0) begin
               word_d  = {16'd0, sign_q, 15'd0};
               flags_d = fin_q;
            end else if (exp_q >= 8'd143) begin
               word_d  = {16'd0, sign_q, 5'h1F, 10'd0};
               flags_d = {1'b1, fin_q[1], 1'b1};
            end else if (exp_q >= 8'd113) begin
               word_d  = {16'd0, w_nrm_word};
               flags_d = {fin_q[2] | w_nrm_inf, fin_q[1], fin_q[0] | w_nrm_g | w_nrm_s};
            end else begin
               sh_d     = {(exp_q != 8'd0), mant_q, 1'b0};
               cnt_d    = w_sub_cnt;
               sticky_d = 1'b0;
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sticky_d = sticky_q | sh_q[0];
            sh_d     = {1'b0, sh_q[24:1]};
            cnt_d    = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = ST_ROUND;
         end
         ST_ROUND: begin
            // A rounding carry into bit 10 naturally forms the smallest normal
            word_d  = {16'd0, sign_q, w_rnd_mag};
            flags_d = {fin_q[2], fin_q[1] | w_rnd_ix, w_rnd_ix};
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (w_hs) status_d = flags_clr ? flags_q : (status_q | flags_q);
      else if (flags_clr) status_d = 3'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mode_q   <= 1'b0;
         sign_q   <= 1'b0;
         exp_q    <= 8'd0;
         mant_q   <= 23'd0;
         fin_q    <= 3'd0;
         sh_q     <= 25'd0;
         cnt_q    <= 5'd0;
         sticky_q <= 1'b0;
         word_q   <= 32'd0;
         flags_q  <= 3'd0;
         status_q <= 3'd0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         fin_q    <= fin_d;
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         word_q   <= word_d;
         flags_q  <= flags_d;
         status_q <= status_d;
      end
   end

   assign in_ready     = (state_q == ST_IDLE);
   assign out_valid    = (state_q == ST_OUT);
   assign out_word     = word_q;
   assign out_flags    = flags_q;
   assign status_flags = status_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_result_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_result_encoder
// Purpose  : Scoreboard bench for fp_result_encoder with a value-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_result_encoder;

   logic        clk, rst, in_valid, in_ready, mode_fp, result_sign;
   logic [7:0]  result_exp;
   logic [22:0] result_mant;
   logic        overflow, underflow, inexact;
   logic        out_valid, out_ready, flags_clr;
   logic [31:0] out_word;
   logic [2:0]  out_flags, status_flags;

   typedef struct {
      logic [31:0] word;
      logic [2:0]  flags;
      int          lat;
      int          acc;
   } exp_t;

   typedef struct {
      bit          md;
      bit          s;
      logic [7:0]  e;
      logic [22:0] m;
      logic [2:0]  fl;
      logic [31:0] w;
      logic [2:0]  f;
      int          lat;
   } vec_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   force_low = 0, force_high = 0, force_clr = 0;

   fp_result_encoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mode_fp(mode_fp), .result_sign(result_sign), .result_exp(result_exp),
      .result_mant(result_mant), .overflow(overflow), .underflow(underflow),
      .inexact(inexact), .out_valid(out_valid), .out_ready(out_ready),
      .out_word(out_word), .out_flags(out_flags), .status_flags(status_flags),
      .flags_clr(flags_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Value-level reference: scale the exact significand to the target quantum
   function automatic exp_t model(input bit md, input bit s, input logic [7:0] e,
                                  input logic [22:0] m, input logic [2:0] fl);
      exp_t   r;
      longint sig, q, rem, half;
      int     ex, k, be;
      bit     ov, uf, ix;
      ov = fl[2]; uf = fl[1]; ix = fl[0];
      r.lat = 2; r.acc = 0;
      if (md) begin
         r.word  = (ov || e == 8'hFF) ? {s, 8'hFF, 23'd0} : {s, e, m};
         r.flags = fl;
         return r;
      end
      if (e == 8'd0 && m == 23'd0) begin
         r.word = {16'd0, s, 15'd0}; r.flags = fl;
         return r;
      end
      if (e >= 8'd143) begin
         r.word = {16'd0, s, 15'h7C00}; r.flags = {1'b1, uf, 1'b1};
         return r;
      end
      ex  = ((e == 8'd0) ? 1 : int'(e)) - 127;
      sig = longint'(m);
      if (e != 8'd0) sig = sig + (longint'(1) << 23);
      k = (ex >= -14) ? 13 : (-ex - 1);
      if (k > 40) k = 40;
      q    = sig >> k;
      rem  = sig - (q << k);
      half = longint'(1) << (k - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      if (rem != 0) ix = 1'b1;
      if (ex >= -14) begin
         be = ex + 15;
         if (q == 2048) begin q = 1024; be = be + 1; end
         if (be >= 31) begin
            r.word = {16'd0, s, 15'h7C00}; ov = 1'b1;
         end else begin
            r.word = {16'd0, s, be[4:0], q[9:0]};
         end
      end else begin
         r.word = {16'd0, s, 15'd0} + 32'(q);
         uf     = uf | ix;
         r.lat  = ((k > 26) ? 26 : k) + 3;
      end
      r.flags = {ov, uf, ix};
      return r;
   endfunction

   task automatic drive_in(input bit md, input bit s, input logic [7:0] e, input logic [22:0] m,
                           input logic [2:0] fl, input logic [31:0] xw, input logic [2:0] xf,
                           input int xl, output int acc);
      int   n;
      exp_t x;
      mode_fp = md; result_sign = s; result_exp = e; result_mant = m;
      {overflow, underflow, inexact} = fl;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL accept_timeout: in_ready got 0 want 1 after %0d cycles", n);
      end
      acc = cyc;
      x.word = xw; x.flags = xf; x.lat = xl; x.acc = cyc;
      sb.push_back(x);
      @(posedge clk); #2;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk); #2;
         n++;
      end
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: outstanding got %0d want 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      out_ready = 1'b0;
      flags_clr = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (force_low)       out_ready = 1'b0;
         else if (force_high) out_ready = 1'b1;
         else                 out_ready = ($urandom % 4) != 0;
         if (force_clr) flags_clr = out_valid;
         else           flags_clr = ($urandom % 16) == 0;
      end
   end

   // Monitor: pops the scoreboard on each output handshake and tracks status
   initial begin
      bit         seen, post_hs, armed;
      logic [2:0] exp_status;
      exp_t       e;
      seen = 0; post_hs = 0; armed = 0; exp_status = 3'd0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            sb.delete();
            exp_status = 3'd0; seen = 0; post_hs = 0; armed = 1;
         end else if (armed) begin
            check("status_flags", 32'(status_flags), 32'(exp_status));
            if (post_hs) begin
               check("in_ready_after_hs", 32'(in_ready), 32'd1);
               post_hs = 0;
            end
            if (out_valid) begin
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_out: got word %h with none pending, want no out_valid", out_word);
               end else begin
                  e = sb[0];
                  if (!seen) begin
                     check("latency", 32'(cyc - e.acc), 32'(e.lat));
                     seen = 1;
                  end
                  check("in_ready_busy", 32'(in_ready), 32'd0);
                  if (out_ready) begin
                     check("out_word", out_word, e.word);
                     check("out_flags", 32'(out_flags), 32'(e.flags));
                     exp_status = flags_clr ? e.flags : (exp_status | e.flags);
                     void'(sb.pop_front());
                     seen = 0; post_hs = 1;
                  end else if (flags_clr) begin
                     exp_status = 3'd0;
                  end
               end
            end else if (flags_clr) begin
               exp_status = 3'd0;
            end
         end
      end
   end

   initial begin
      vec_t dir[13];
      exp_t r;
      int   acc, n;
      rst = 1'b1; in_valid = 1'b0; mode_fp = 1'b0; result_sign = 1'b0;
      result_exp = 8'd0; result_mant = 23'd0;
      overflow = 1'b0; underflow = 1'b0; inexact = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_word", out_word, 32'd0);
      check("rst_out_flags", 32'(out_flags), 32'd0);
      check("rst_status", 32'(status_flags), 32'd0);

      dir[0]  = '{1'b1, 1'b0, 8'h7F, 23'h400000, 3'b000, 32'h3FC00000, 3'b000, 2};
      dir[1]  = '{1'b1, 1'b0, 8'h7F, 23'h400000, 3'b100, 32'h7F800000, 3'b100, 2};
      dir[2]  = '{1'b0, 1'b0, 8'h7F, 23'h000000, 3'b000, 32'h00003C00, 3'b000, 2};
      dir[3]  = '{1'b0, 1'b0, 8'h7F, 23'h001000, 3'b000, 32'h00003C00, 3'b001, 2};
      dir[4]  = '{1'b0, 1'b0, 8'h7F, 23'h003000, 3'b000, 32'h00003C02, 3'b001, 2};
      dir[5]  = '{1'b0, 1'b0, 8'h8F, 23'h000000, 3'b000, 32'h00007C00, 3'b101, 2};
      dir[6]  = '{1'b0, 1'b0, 8'h8E, 23'h7FF000, 3'b000, 32'h00007C00, 3'b101, 2};
      dir[7]  = '{1'b0, 1'b0, 8'h70, 23'h000000, 3'b000, 32'h00000200, 3'b000, 17};
      dir[8]  = '{1'b0, 1'b1, 8'h66, 23'h000000, 3'b000, 32'h00008000, 3'b011, 27};
      dir[9]  = '{1'b0, 1'b0, 8'h70, 23'h7FF000, 3'b000, 32'h00000400, 3'b011, 17};
      dir[10] = '{1'b0, 1'b1, 8'h00, 23'h000000, 3'b000, 32'h00008000, 3'b000, 2};
      dir[11] = '{1'b0, 1'b0, 8'h00, 23'h000001, 3'b000, 32'h00000000, 3'b011, 29};
      dir[12] = '{1'b1, 1'b0, 8'hFF, 23'h000123, 3'b000, 32'h7F800000, 3'b000, 2};
      for (int i = 0; i < 13; i++)
         drive_in(dir[i].md, dir[i].s, dir[i].e, dir[i].m, dir[i].fl,
                  dir[i].w, dir[i].f, dir[i].lat, acc);
      drain();

      // Backpressure, then a handshake coinciding with flags_clr
      drive_in(1'b0, 1'b1, 8'h66, 23'd0, 3'b000, 32'h00008000, 3'b011, 27, acc);
      drain();
      force_low = 1;
      drive_in(1'b0, 1'b0, 8'h8F, 23'd0, 3'b000, 32'h00007C00, 3'b101, 2, acc);
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #2; n++; end
      check("bp_valid_rise", 32'(out_valid), 32'd1);
      repeat (5) begin
         @(posedge clk); #2;
         check("bp_word", out_word, 32'h00007C00);
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      force_low = 0; force_high = 1; force_clr = 1;
      n = 0;
      while (out_valid && n < 10) begin @(posedge clk); #2; n++; end
      check("status_clr_hs", 32'(status_flags), 32'(3'b101));
      force_high = 0; force_clr = 0;
      drain();

      // Reset in the middle of a subnormal shift
      drive_in(1'b0, 1'b0, 8'h70, 23'd0, 3'b000, 32'h00000200, 3'b000, 17, acc);
      while (cyc < acc + 6) begin @(posedge clk); #2; end
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      repeat (25) @(posedge clk);
      #2;
      drive_in(1'b1, 1'b1, 8'h81, 23'h123456, 3'b001, 32'hC0923456, 3'b001, 2, acc);
      drain();

      for (int i = 0; i < 150; i++) begin
         bit          md, s;
         logic [7:0]  e;
         logic [22:0] m;
         logic [2:0]  fl;
         md = ($urandom % 3) == 0;
         s  = 1'($urandom);
         case ($urandom % 4)
            0:       e = 8'($urandom);
            1:       e = 8'($urandom_range(145, 100));
            2:       e = 8'($urandom_range(116, 96));
            default: e = (($urandom % 2) == 0) ? 8'h00 : 8'hFF;
         endcase
         case ($urandom % 3)
            0:       m = 23'($urandom);
            1:       m = 23'h7FF000 | 23'($urandom % 4096);
            default: m = (23'($urandom) & 23'h7FE000) | ((($urandom % 2) == 0) ? 23'h001000 : 23'h0);
         endcase
         fl = (($urandom % 4) == 0) ? 3'($urandom) : 3'b000;
         r  = model(md, s, e, m, fl);
         drive_in(md, s, e, m, fl, r.word, r.flags, r.lat, acc);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fp_result_encoder.md
# fp_result_encoder

Output stage of the floating-point datapath: accepts unpacked result fields (sign, 8-bit biased exponent, 23-bit fraction, exception flags) from the add/sub unit and packs them into an IEEE-754 word. In single mode the fields pass straight through. In half mode the block rebiases the exponent, rounds to nearest-even, and builds subnormals with an iterative one-bit-per-cycle shifter. It uses a valid/ready handshake on both sides and keeps a sticky exception status register.

## Interface
- No parameters. Exponent bias conversion is fixed: single 127, half 15, offset 112.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input fields are valid.
- `in_ready` out 1: high only in IDLE.
- `mode_fp` in 1: 0 = half, 1 = single; sampled at accept.
- `result_sign` in 1, `result_exp` in 8, `result_mant` in 23: unpacked value, single-precision bias.
- `overflow`, `underflow`, `inexact` in 1 each: flags from the producing unit.
- `out_valid` out 1: packed result valid.
- `out_ready` in 1: consumer accepts.
- `out_word` out 32: packed word; half results sit in [15:0] with [31:16] = 0.
- `out_flags` out 3: {overflow, underflow, inexact} for `out_word`.
- `status_flags` out 3: sticky OR of `out_flags` over all completed handshakes.
- `flags_clr` in 1: clears `status_flags`.

## Operation
- **States:** IDLE → CALC → (SHIFT → ROUND) → OUT → IDLE.
- **Accept:** `in_valid & in_ready` latches all inputs. Next state is CALC.

**CALC, single mode**
- word = {s, e, m}; flags pass through; next state OUT.
- If `overflow` or e = 8'hFF: word = {s, 8'hFF, 23'b0}.

**CALC, half mode**
- e = 0 and m = 0: word = {s, 15'b0}; flags pass through.
- e ≥ 143: infinity {s, 5'h1F, 10'b0}; overflow = 1, inexact = 1.
- 113 ≤ e ≤ 142: normal result.
  - Exponent e5 = e − 112; fraction f = m[22:13].
  - Guard G = m[12]; sticky S = |m[11:0].
  - Round up when G & (S | f[0]).
  - If the fraction carries out, then f = 0 and e5 += 1. If e5 reaches 31 the result is infinity with overflow = 1.
  - inexact |= G | S.
  - Next state OUT.
- Otherwise the result is subnormal.
  - Shift register R (25 b) = {sig24, 1'b0}, where sig24 = {1, m}. When e = 0, sig24 = {0, m} and e is treated as 1.
  - Shift count s = min(126 − e, 26). The minimum is 14.
  - Clear sticky. Next state SHIFT.

**SHIFT**
- Each cycle: sticky |= R[0], R >>= 1, count −= 1.
- After s cycles, next state ROUND.

**ROUND**
- q = R[24:1], G = R[0].
- Round up when G & (sticky | q[0]).
- Word = {s, 15'b0} + q, so a carry into bit 10 yields the smallest normal 0x0400.
- inexact |= G | sticky; underflow |= inexact.

**OUT**
- Holds `out_valid`, `out_word` and `out_flags` stable until `out_ready`, then returns to IDLE.

**status_flags**
- On handshake: status |= out_flags.
- `flags_clr` alone: status = 0.
- `flags_clr` together with a handshake: status = out_flags of that handshake only.

## Timing
- Reset: state IDLE, `in_ready` = 1, `out_valid` = 0, `out_word` = 0, `out_flags` = 0, `status_flags` = 0, shifter and counter cleared.
- Reset mid-operation, in any state, discards the in-flight transaction and produces no output.
- Counting the accept edge as cycle 0:
  - Single mode and half normal/inf/zero: `out_valid` rises in cycle 2.
  - Half subnormal: `out_valid` rises in cycle s + 3, giving a worst case of 29.
- `in_ready` is 0 from cycle 1 until the cycle after the output handshake. There is no overlap, so the minimum initiation interval is 3 cycles.
- `out_ready` may be high before `out_valid`; the handshake completes in the first OUT cycle.
- `in_ready` is a registered state decode; it has no combinational path from `out_ready`.

## Test plan
- **Single pass-through:** mode 1, s = 0, e = 0x7F, m = 0x400000 → `out_word` 0x3FC00000, flags 000, `out_valid` in cycle 2. Same with `overflow` = 1 → 0x7F800000, flags 100.
- **Half normal and RNE:**
  - e = 0x7F, m = 0 → 0x00003C00.
  - m = 0x001000 → 0x3C00, inexact (tie to even).
  - m = 0x003000 → 0x3C02, inexact.
- **Half overflow:**
  - e = 0x8F → 0x7C00, flags 101.
  - e = 0x8E, m = 0x7FF000 → rounding carry → 0x7C00, flags 101.
- **Half subnormal:**
  - e = 0x70, m = 0 → 0x0200, flags 000, `out_valid` in cycle 17.
  - s = 1, e = 0x66, m = 0 → 0x8000, flags 011.
  - e = 0x70, m = 0x7FF000: q = 0x3FF, G = 1 → 0x0400, flags 011.
- **Backpressure and status:**
  - Hold `out_ready` low for 5 cycles → word stable, `in_ready` = 0.
  - Handshake with `flags_clr` in the same cycle → `status_flags` equals that result's flags.
- **Reset in SHIFT:** assert `rst` during cycle 6 of a subnormal → no `out_valid`, `in_ready` = 1 next cycle, then a new input completes normally.
